// File: rtl/comb_harness_pkg.sv
// Shared state encoding and counter sizing for the combinational-cone harness.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package comb_harness_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_SETTLE,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_PARITY,
        S_DONE
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/harness_shift_reg.sv
// Width-parameterised shift register: serial-in/parallel-out and parallel-load/serial-out, MSB-first.
// Latency: one cycle from load/shift to q.
// Backpressure: none; load wins over shift when both are asserted.
module harness_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    logic [W-1:0] shifted;

    generate
        if (W == 1) begin : g_w1
            assign shifted = sin;
        end else begin : g_wn
            assign shifted = {q[W-2:0], sin};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_dat;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/comb_harness_driver.sv
// Serial frame in -> apply register -> settle -> capture cone outputs -> serial out (optional even parity via COMB_HARNESS_PARITY_EN).
// Latency: 1 + IN_W + SETTLE + 1 + OUT_W + 1 cycles per frame plus si stalls (+1 with parity).
// Backpressure: si stalls via si_valid; so has no backpressure; start ignored while busy.
module comb_harness_driver
    import comb_harness_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             si,
    input  logic             si_valid,
    output logic [IN_W-1:0]  comb_in,
    input  logic [OUT_W-1:0] comb_out,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(IN_W, OUT_W, SETTLE);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_W - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_W - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_acc, in_last, out_load, out_shift;
    logic [IN_W-1:0] in_q, in_nxt;
    logic [OUT_W-1:0] out_q;

    harness_shift_reg #(.W(IN_W)) u_in_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_dat ({IN_W{1'b0}}),
        .shift    (in_acc),
        .sin      (si),
        .q        (in_q)
    );

    // Output register rotates so the captured word is intact again for parity.
    harness_shift_reg #(.W(OUT_W)) u_out_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (out_load),
        .load_dat (comb_out),
        .shift    (out_shift),
        .sin      (out_q[OUT_W-1]),
        .q        (out_q)
    );

    // The apply register takes the completed word in the same edge as the last bit.
    generate
        if (IN_W == 1) begin : g_nxt_w1
            assign in_nxt = si;
        end else begin : g_nxt_wn
            assign in_nxt = {in_q[IN_W-2:0], si};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_load  = 1'b0;
        out_shift = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = '0;
                end
            end
            S_SHIFT_IN: begin
                if (si_valid) begin
                    in_acc = 1'b1;
                    if (cnt_q == IN_LAST) begin
                        in_last = 1'b1;
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                out_load = 1'b1;
                state_d  = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                out_shift = 1'b1;
                if (cnt_q == OUT_LAST) begin
                    cnt_d = '0;
`ifdef COMB_HARNESS_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            comb_in <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_last) begin
                comb_in <= in_nxt;
            end
        end
    end

    always_comb begin
        so       = 1'b0;
        so_valid = 1'b0;
        if (state_q == S_SHIFT_OUT) begin
            so       = out_q[OUT_W-1];
            so_valid = 1'b1;
        end
`ifdef COMB_HARNESS_PARITY_EN
        if (state_q == S_PARITY) begin
            so       = ^out_q;
            so_valid = 1'b1;
        end
`endif
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: doc/comb_harness_driver.md
# comb_harness_driver

Register-bank harness that re-wraps an extracted combinational cone for stand-alone evaluation. A serial input frame is shifted into a parallel apply register that drives the cone. After a programmable settle time, the cone outputs are captured and shifted back out serially. It is the counterpart of combinational extraction: extraction strips a netlist's flip-flops, and this block supplies their state from the host side and returns the cone's response.

## Interface
Parameters:
- IN_W, 3: number of cone inputs (former register outputs); ≥1
- OUT_W, 2: number of cone outputs (former register inputs); ≥1
- SETTLE, 1: cycles between apply and capture; ≥1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to begin a frame; sampled only in IDLE
- si  in  1  serial input data bit
- si_valid  in  1  si carries a valid bit this cycle
- comb_in  out  IN_W  apply register, drives the cone inputs
- comb_out  in  OUT_W  cone outputs, sampled in CAPTURE
- so  out  1  serial output data bit
- so_valid  out  1  so is valid this cycle; no backpressure
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a frame

## Operation
- States and transitions:
  - IDLE: start=1 → SHIFT_IN.
  - SHIFT_IN: after IN_W accepted bits → SETTLE.
  - SETTLE: after SETTLE cycles → CAPTURE.
  - CAPTURE: 1 cycle → SHIFT_OUT.
  - SHIFT_OUT: after OUT_W bits → PARITY if configured, otherwise DONE.
  - PARITY: 1 cycle → DONE.
  - DONE: 1 cycle → IDLE.
- SHIFT_IN:
  - A bit is accepted only when si_valid=1. Stalls of any length are allowed.
  - Bits are shifted MSB-first: the first accepted bit becomes bit IN_W-1.
  - The si_valid value in the same cycle as start is ignored.
- comb_in updates only once, on the edge that accepts the last bit. It then holds its value until the next frame's last bit or until reset. It never shows a partial frame.
- CAPTURE: the capture register loads comb_out at the end of the cycle.
- SHIFT_OUT: so presents the capture register MSB-first, one bit per cycle, with so_valid=1.
- start while busy=1 is ignored. It is neither queued nor an error.
- Reset values: comb_in=0, so=0, so_valid=0, busy=0, done=0, state=IDLE, all counters 0.
- Reset mid-frame aborts immediately. No done pulse is issued and comb_in returns to 0.
- Counter widths: $clog2(max(IN_W,OUT_W,SETTLE)+1). Counters never wrap within a frame.

## Timing
Example: IN_W=3, OUT_W=2, SETTLE=1, start high in cycle 0, si_valid high continuously from cycle 1.
- Cycles 1–3: SHIFT_IN; busy=1 from cycle 1.
- Cycle 4: new comb_in visible; SETTLE.
- Cycle 5: CAPTURE.
- Cycles 6–7: so_valid=1.
- Cycle 8: done=1.
- Cycle 9: IDLE; busy=0. A start in cycle 9 is accepted.
- General frame length: 1 + IN_W + SETTLE + 1 + OUT_W + 1 cycles, plus si stall cycles, plus 1 if PARITY is compiled in.

## Configuration
- COMB_HARNESS_PARITY_EN defined:
  - PARITY state is present. After the last data bit, so carries the even-parity bit (XOR of the capture register) with so_valid=1.
  - DONE is delayed by one cycle.
- COMB_HARNESS_PARITY_EN undefined:
  - No PARITY state. SHIFT_OUT goes directly to DONE.

## Structure
- Package comb_harness_pkg:
  - state enum (IDLE, SHIFT_IN, SETTLE, CAPTURE, SHIFT_OUT, PARITY, DONE)
  - function computing the counter width
- Sub-module harness_shift_reg: parameterised width, serial-in/parallel-out and parallel-load/serial-out shift register, instantiated once for input and once for output.
- The top level holds the FSM, the counters, and the comb_in apply register.

## Test plan
In all scenarios the bench models the cone as comb_out[1] = ~(comb_in[2] & comb_in[1]) and comb_out[0] = comb_in[0]. IN_W=3, OUT_W=2, SETTLE=1.
- Frame 1,1,0 with continuous si_valid → comb_in=3'b110 in cycle 4; so=0,0 in cycles 6–7; done in cycle 8.
- Frame 0,1,1 → comb_in=3'b011; so=1,1. With COMB_HARNESS_PARITY_EN, so=0 in the parity cycle and done in cycle 9.
- si_valid toggling 1,0,0,1,0,1 → exactly three bits accepted; comb_in does not change before the third accepted bit; the frame is extended by 3 cycles.
- start pulses during SHIFT_IN and SHIFT_OUT → ignored; exactly one done per frame.
- rst asserted in SETTLE → the next cycle shows IDLE, comb_in=0, busy=0, and no done pulse. A fresh frame afterwards completes normally.
- Back-to-back frames (start in the cycle after done) → the second frame's result is correct, and comb_in holds the first frame's value until the second frame's last input bit.
